// File: rtl/uart_tx_feeder.sv
// UART Tx front-end: byte FIFO plus a frame-at-a-time handshake to the PISO serializer.
// Define UART_TX_FEEDER_OVF_EN to build the sticky overflow flag; otherwise ovf is tied to 0.
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                          baud_clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          ovf,
    output logic                          piso_send,
    output logic [DATA_WIDTH-1:0]         piso_data,
    output logic                          piso_parity,
    input  logic                          piso_active,
    input  logic                          piso_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q, count_d;
    logic                    send_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    parity_q;
    logic                    push, pop;

    function automatic logic parity_f(input logic [DATA_WIDTH-1:0] b);
        parity_f = (PARITY_ODD != 0) ? ~^b : ^b;
    endfunction

    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign busy        = (state_q != IDLE);
    assign piso_send   = send_q;
    assign piso_data   = data_q;
    assign piso_parity = parity_q;
    // A write against a full FIFO is dropped even if a pop frees a slot at the same edge.
    assign push        = wr_en && !full;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD:       state_d = WAIT_START;
            // A done level left over from the previous frame must not end this one.
            WAIT_START: if (piso_active) state_d = WAIT_DONE;
            WAIT_DONE:  if (piso_done)   state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            send_q   <= 1'b0;
            data_q   <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            send_q  <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                data_q   <= mem_q[rd_ptr_q];
                parity_q <= parity_f(mem_q[rd_ptr_q]);
            end
        end
    end

    always_ff @(posedge baud_clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

`ifdef UART_TX_FEEDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge baud_clk) begin
        if (rst)               ovf_q <= 1'b0;
        else if (wr_en && full) ovf_q <= 1'b1;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: queue reference model, serializer model, even and odd parity instances.
module tb_uart_tx_feeder;
    localparam int DEPTH = 4;
`ifdef UART_TX_FEEDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       baud_clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty, busy, ovf, piso_send, piso_parity;
    logic [2:0] count;
    logic [7:0] piso_data;
    logic       piso_active = 1'b0;
    logic       piso_done   = 1'b0;
    logic       o_full, o_empty, o_busy, o_ovf, o_send, o_parity;
    logic [2:0] o_count;
    logic [7:0] o_data;

    uart_tx_feeder #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) u_even (
        .baud_clk(baud_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .busy(busy), .ovf(ovf),
        .piso_send(piso_send), .piso_data(piso_data), .piso_parity(piso_parity),
        .piso_active(piso_active), .piso_done(piso_done));

    uart_tx_feeder #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)) u_odd (
        .baud_clk(baud_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(o_full), .empty(o_empty), .count(o_count), .busy(o_busy), .ovf(o_ovf),
        .piso_send(o_send), .piso_data(o_data), .piso_parity(o_parity),
        .piso_active(piso_active), .piso_done(piso_done));

    always #5 baud_clk = ~baud_clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         done_edge = -10;
    bit         gap_armed = 0;
    bit         drop_seen = 0;
    bit         prev_send = 0;
    bit         ser_busy = 0, ser_started = 0, ser_rand = 0;
    int         ser_delay = 0, ser_len = 0, ser_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic ref_parity(input logic [7:0] b, input bit odd);
        int ones;
        ones = $countones(b);
        return logic'((ones % 2) == 1) ^ odd;
    endfunction

    // Reference FIFO: a write is kept iff fewer than DEPTH bytes are waiting at that edge.
    initial forever begin
        @(posedge baud_clk);
        cyc++;
        if (rst) begin
            exp_q.delete();
            drop_seen = 0;
            gap_armed = 0;
        end else begin
            if (wr_en) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(wr_data);
                else drop_seen = 1;
            end
            if (cyc == done_edge && exp_q.size() > 0) gap_armed = 1;
        end
    end

    // Monitor plus serializer model; done stays high as a stale level until the next frame starts.
    initial forever begin
        logic [7:0] e;
        @(negedge baud_clk);
        if (gap_armed && cyc == done_edge + 1) begin
            check("gap_after_done", piso_send, 1'b1);
            gap_armed = 0;
        end
        if (piso_send) begin
            check("pulse_width", prev_send, 1'b0);
            check("send_while_serializing", ser_busy, 1'b0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_send: got data %0h, expected no send (cycle %0d)", piso_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("data", piso_data, e);
                check("parity_even", piso_parity, ref_parity(e, 1'b0));
                check("odd_data", o_data, e);
                check("parity_odd", o_parity, ref_parity(e, 1'b1));
            end
            ser_busy    = 1;
            ser_started = 0;
            ser_delay   = ser_rand ? $urandom_range(0, 2) : 0;
            ser_len     = ser_rand ? $urandom_range(1, 8) : 10;
        end else if (ser_busy) begin
            if (ser_delay > 0) begin
                ser_delay--;
            end else if (!ser_started) begin
                ser_started = 1;
                piso_active = 1'b1;
                piso_done   = 1'b0;
                ser_cnt     = ser_len;
            end else begin
                ser_cnt--;
                if (ser_cnt == 0) begin
                    piso_active = 1'b0;
                    piso_done   = 1'b1;
                    ser_busy    = 0;
                    done_edge   = cyc + 1;
                end
            end
        end
        check("count", count, exp_q.size());
        check("full", full, exp_q.size() == DEPTH);
        check("empty", empty, exp_q.size() == 0);
        check("ovf", ovf, OVF_EN & drop_seen);
        check("ovf_odd", o_ovf, OVF_EN & drop_seen);
        prev_send = piso_send;
    end

    task automatic drive(input logic en, input logic [7:0] d);
        @(negedge baud_clk);
        #1;
        wr_en   = en;
        wr_data = d;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ser_busy || busy) && n < max) begin
            drive(1'b0, 8'h00);
            n++;
        end
        total++;
        if (n >= max) begin
            bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
        end
        repeat (2) drive(1'b0, 8'h00);
    endtask

    initial begin
        int n;
        bit found;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        repeat (3) @(negedge baud_clk);
        #1 rst = 1'b0;
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_send", piso_send, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_data", piso_data, 8'h00);

        drive(1'b1, 8'hAA); drive(1'b0, 8'h00);
        wait_idle(100);
        drive(1'b1, 8'h07); drive(1'b0, 8'h00);
        wait_idle(100);

        drive(1'b1, 8'hA1); drive(1'b1, 8'hB2); drive(1'b1, 8'hC3); drive(1'b0, 8'h00);
        wait_idle(200);

        for (int i = 0; i < 5; i++) drive(1'b1, 8'h10 + 8'(i));
        drive(1'b1, 8'hFF);
        drive(1'b0, 8'h00);
        check("fill_full", full, 1'b1);
        check("fill_count", count, 4);
        check("fill_ovf", ovf, OVF_EN);

        wr_en = 1'b1; wr_data = 8'hEE;
        found = 0;
        n = 0;
        while (!found && n < 40) begin
            @(negedge baud_clk);
            #1;
            if (piso_send) begin
                wr_en = 1'b0;
                found = 1;
                check("pop_with_write_count", count, 3);
            end
            n++;
        end
        wr_en = 1'b0;
        if (!found) check("pop_with_write_seen", 1'b0, 1'b1);
        wait_idle(200);

        drive(1'b1, 8'h31); drive(1'b1, 8'h32); drive(1'b1, 8'h33); drive(1'b0, 8'h00);
        n = 0;
        while (!piso_active && n < 20) begin
            drive(1'b0, 8'h00);
            n++;
        end
        check("active_seen", piso_active, 1'b1);
        repeat (2) drive(1'b0, 8'h00);
        check("queued_before_rst", count, 2);
        @(negedge baud_clk); #1 rst = 1'b1;
        @(negedge baud_clk); #1 rst = 1'b0;
        check("midrst_empty", empty, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_send", piso_send, 1'b0);
        check("midrst_count", count, 0);
        check("midrst_ovf", ovf, 1'b0);
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 8'h00);
            check("post_rst_busy", busy, 1'b0);
        end
        wait_idle(100);

        ser_rand = 1;
        for (int i = 0; i < 600; i++) drive($urandom_range(0, 2) == 0, 8'($urandom));
        drive(1'b0, 8'h00);
        wait_idle(1000);

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
